// File: rtl/ex_stage.sv
// ex_stage: execute stage of the 5-stage pipeline.
// Evaluates the ALU and the branch/jump decision. MUL is handled by an
// iterative 32-cycle shift-add multiplier, and upstream stages stall while it runs.
// Ports:
//   clk_in, n_rst_in            clock, async active-low reset
//   IDEX_*_in                   ID/EX pipeline register (pc+4, ir, rs/rt values, controls)
//   EXMEM_*_out                 EX/MEM pipeline register (result, store data, dest, controls)
//   EXMEM_branch_taken/target   one-cycle PC redirect to fetch
//   stall_out                   combinational; holds IF/ID and ID/EX while high
module ex_stage (
    input  logic        clk_in,
    input  logic        n_rst_in,
    input  logic [31:0] IDEX_pc_in,
    input  logic [31:0] IDEX_ir_in,
    input  logic [31:0] IDEX_a_in,
    input  logic [31:0] IDEX_b_in,
    input  logic        IDEX_ctrl_reg_dst_in,
    input  logic        IDEX_ctrl_alu_src_in,
    input  logic        IDEX_ctrl_branch_in,
    input  logic        IDEX_ctrl_reg_write_in,
    input  logic        IDEX_ctrl_mem_to_reg_in,
    input  logic [1:0]  IDEX_ctrl_mem_read_in,
    input  logic [1:0]  IDEX_ctrl_mem_write_in,
    output logic [31:0] EXMEM_alu_result_out,
    output logic [31:0] EXMEM_b_out,
    output logic [4:0]  EXMEM_reg_write_address_out,
    output logic [1:0]  EXMEM_ctrl_mem_read_out,
    output logic [1:0]  EXMEM_ctrl_mem_write_out,
    output logic        EXMEM_ctrl_reg_write_out,
    output logic        EXMEM_ctrl_mem_to_reg_out,
    output logic        EXMEM_branch_taken_out,
    output logic [31:0] EXMEM_branch_target_out,
    output logic        stall_out
);

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 5;
    localparam int unsigned REG_W = 5;

    // Opcode encodings
    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_JAL  = 6'h03;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_BNE  = 6'h05;
    localparam logic [5:0] OP_BLT  = 6'h06;
    localparam logic [5:0] OP_BLE  = 6'h07;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_ANDI = 6'h0C;
    localparam logic [5:0] OP_ORI  = 6'h0D;
    localparam logic [5:0] OP_XORI = 6'h0E;
    localparam logic [5:0] OP_LUI  = 6'h0F;
    localparam logic [5:0] OP_LB   = 6'h20;
    localparam logic [5:0] OP_LH   = 6'h21;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SB   = 6'h28;
    localparam logic [5:0] OP_SH   = 6'h29;
    localparam logic [5:0] OP_SW   = 6'h2B;

    // R-type funct encodings
    localparam logic [5:0] F_SLL = 6'h00;
    localparam logic [5:0] F_SRL = 6'h02;
    localparam logic [5:0] F_SRA = 6'h03;
    localparam logic [5:0] F_JR  = 6'h08;
    localparam logic [5:0] F_MUL = 6'h18;
    localparam logic [5:0] F_ADD = 6'h20;
    localparam logic [5:0] F_SUB = 6'h22;
    localparam logic [5:0] F_AND = 6'h24;
    localparam logic [5:0] F_OR  = 6'h25;
    localparam logic [5:0] F_XOR = 6'h26;
    localparam logic [5:0] F_NOR = 6'h27;
    localparam logic [5:0] F_SLT = 6'h2A;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } mul_state_e;

    // Instruction fields
    logic [5:0]       op;
    logic [5:0]       funct;
    logic [4:0]       shamt;
    logic [15:0]      imm;
    logic [XLEN-1:0]  imm_sext;
    logic [XLEN-1:0]  imm_ext;
    logic [XLEN-1:0]  op_b;
    logic [XLEN-1:0]  alu_res;
    logic             br_taken;
    logic [XLEN-1:0]  br_tgt;
    logic [REG_W-1:0] dest;
    logic             squash;
    logic             is_mul;
    logic             mul_start;

    // Multiplier state
    mul_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0]  mcand_q, mcand_d;
    logic [XLEN-1:0]  mplier_q, mplier_d;
    logic [XLEN-1:0]  acc_q, acc_d;

    // EX/MEM register
    logic [XLEN-1:0]  res_q, res_d;
    logic [XLEN-1:0]  bdat_q, bdat_d;
    logic [REG_W-1:0] rd_q, rd_d;
    logic [1:0]       mr_q, mr_d;
    logic [1:0]       mw_q, mw_d;
    logic             rw_q, rw_d;
    logic             m2r_q, m2r_d;
    logic             tk_q, tk_d;
    logic [XLEN-1:0]  tgt_q, tgt_d;

    assign op       = IDEX_ir_in[31:26];
    assign funct    = IDEX_ir_in[5:0];
    assign shamt    = IDEX_ir_in[10:6];
    assign imm      = IDEX_ir_in[15:0];
    assign imm_sext = {{16{imm[15]}}, imm};

    // Immediate extension depends on the opcode class
    always_comb begin
        imm_ext = imm_sext;
        case (op)
            OP_ANDI, OP_ORI, OP_XORI: imm_ext = {16'h0000, imm};
            OP_LUI:                   imm_ext = {imm, 16'h0000};
            default:                  imm_ext = imm_sext;
        endcase
    end

    assign op_b = IDEX_ctrl_alu_src_in ? imm_ext : IDEX_b_in;

    // ALU; MUL's product comes from the iterative multiplier, not from here
    always_comb begin
        alu_res = '0;
        case (op)
            OP_R: begin
                case (funct)
                    F_ADD:   alu_res = IDEX_a_in + op_b;
                    F_SUB:   alu_res = IDEX_a_in - op_b;
                    F_AND:   alu_res = IDEX_a_in & op_b;
                    F_OR:    alu_res = IDEX_a_in | op_b;
                    F_XOR:   alu_res = IDEX_a_in ^ op_b;
                    F_NOR:   alu_res = ~(IDEX_a_in | op_b);
                    F_SLT:   alu_res = {31'd0, ($signed(IDEX_a_in) < $signed(op_b))};
                    F_SLL:   alu_res = op_b << shamt;
                    F_SRL:   alu_res = op_b >> shamt;
                    F_SRA:   alu_res = XLEN'($signed(op_b) >>> shamt);
                    default: alu_res = '0;
                endcase
            end
            OP_ADDI, OP_LB, OP_LH, OP_LW, OP_SB, OP_SH, OP_SW:
                     alu_res = IDEX_a_in + op_b;
            OP_ANDI: alu_res = IDEX_a_in & op_b;
            OP_ORI:  alu_res = IDEX_a_in | op_b;
            OP_XORI: alu_res = IDEX_a_in ^ op_b;
            OP_LUI:  alu_res = op_b;
            OP_JAL:  alu_res = IDEX_pc_in;
            default: alu_res = '0;
        endcase
    end

    // Branch/jump decision; target is forced to 0 when not taken
    always_comb begin
        br_taken = 1'b0;
        br_tgt   = '0;
        case (op)
            OP_BEQ: br_taken = IDEX_ctrl_branch_in && (IDEX_a_in == IDEX_b_in);
            OP_BNE: br_taken = IDEX_ctrl_branch_in && (IDEX_a_in != IDEX_b_in);
            OP_BLT: br_taken = IDEX_ctrl_branch_in && ($signed(IDEX_a_in) < $signed(IDEX_b_in));
            OP_BLE: br_taken = IDEX_ctrl_branch_in && ($signed(IDEX_a_in) <= $signed(IDEX_b_in));
            OP_J, OP_JAL, OP_R: br_taken = 1'b0;
            default: br_taken = 1'b0;
        endcase
        if (br_taken) begin
            br_tgt = IDEX_pc_in + (imm_sext << 2);
        end
        if (op == OP_J || op == OP_JAL) begin
            br_taken = 1'b1;
            br_tgt   = {IDEX_pc_in[31:28], IDEX_ir_in[25:0], 2'b00};
        end
        if (op == OP_R && funct == F_JR) begin
            br_taken = 1'b1;
            br_tgt   = IDEX_a_in;
        end
    end

    assign dest = (op == OP_JAL)         ? REG_W'(31) :
                  IDEX_ctrl_reg_dst_in   ? IDEX_ir_in[15:11] : IDEX_ir_in[20:16];

    // The instruction in EX is wrong-path while the previous redirect is visible
    assign squash    = tk_q;
    assign is_mul    = (op == OP_R) && (funct == F_MUL);
    assign mul_start = (state_q == S_IDLE) && is_mul && !squash;
    assign stall_out = n_rst_in && (mul_start || (state_q == S_BUSY));

    // Next-state: multiplier FSM and EX/MEM contents (bubble by default)
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        res_d    = '0;
        bdat_d   = '0;
        rd_d     = '0;
        mr_d     = '0;
        mw_d     = '0;
        rw_d     = 1'b0;
        m2r_d    = 1'b0;
        tk_d     = 1'b0;
        tgt_d    = '0;
        case (state_q)
            S_IDLE: begin
                if (mul_start) begin
                    mcand_d  = IDEX_a_in;
                    mplier_d = IDEX_b_in;
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = S_BUSY;
                end else if (!squash) begin
                    res_d  = alu_res;
                    bdat_d = IDEX_b_in;
                    rd_d   = dest;
                    mr_d   = IDEX_ctrl_mem_read_in;
                    mw_d   = IDEX_ctrl_mem_write_in;
                    rw_d   = IDEX_ctrl_reg_write_in;
                    m2r_d  = IDEX_ctrl_mem_to_reg_in;
                    tk_d   = br_taken;
                    tgt_d  = br_tgt;
                end
            end
            S_BUSY: begin
                // One shift-add step per cycle, LSB of multiplier first
                if (mplier_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = CNT_W'(cnt_q + CNT_W'(1));
                if (cnt_q == CNT_W'(31)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                // IDEX still holds the MUL; return to IDLE without restarting
                res_d   = acc_q;
                bdat_d  = IDEX_b_in;
                rd_d    = dest;
                mr_d    = IDEX_ctrl_mem_read_in;
                mw_d    = IDEX_ctrl_mem_write_in;
                rw_d    = IDEX_ctrl_reg_write_in;
                m2r_d   = IDEX_ctrl_mem_to_reg_in;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and EX/MEM registers
    always_ff @(posedge clk_in or negedge n_rst_in) begin
        if (!n_rst_in) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            res_q    <= '0;
            bdat_q   <= '0;
            rd_q     <= '0;
            mr_q     <= '0;
            mw_q     <= '0;
            rw_q     <= 1'b0;
            m2r_q    <= 1'b0;
            tk_q     <= 1'b0;
            tgt_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            res_q    <= res_d;
            bdat_q   <= bdat_d;
            rd_q     <= rd_d;
            mr_q     <= mr_d;
            mw_q     <= mw_d;
            rw_q     <= rw_d;
            m2r_q    <= m2r_d;
            tk_q     <= tk_d;
            tgt_q    <= tgt_d;
        end
    end

    assign EXMEM_alu_result_out        = res_q;
    assign EXMEM_b_out                 = bdat_q;
    assign EXMEM_reg_write_address_out = rd_q;
    assign EXMEM_ctrl_mem_read_out     = mr_q;
    assign EXMEM_ctrl_mem_write_out    = mw_q;
    assign EXMEM_ctrl_reg_write_out    = rw_q;
    assign EXMEM_ctrl_mem_to_reg_out   = m2r_q;
    assign EXMEM_branch_taken_out      = tk_q;
    assign EXMEM_branch_target_out     = tgt_q;

endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed scoreboard bench for ex_stage.
// Stimulus pushes expected EX/MEM contents and stall_out values, each tagged
// with the clock edge they belong to; a monitor on the falling edge pops and compares.
module tb_ex_stage;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_JAL  = 6'h03;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_BNE  = 6'h05;
    localparam logic [5:0] OP_BLT  = 6'h06;
    localparam logic [5:0] OP_BLE  = 6'h07;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_ORI  = 6'h0D;
    localparam logic [5:0] OP_XORI = 6'h0E;
    localparam logic [5:0] OP_LUI  = 6'h0F;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;

    typedef struct {
        logic [31:0] pc, ir, a, b;
        logic        rdst, asrc, br, rw, m2r;
        logic [1:0]  mr, mw;
    } in_t;

    typedef struct {
        int           cyc;
        bit           ck_ex;
        bit           ck_st;
        logic [107:0] ex;
        logic         st;
        logic [63:0]  name;
    } exp_t;

    logic        clk_in   = 1'b0;
    logic        n_rst_in = 1'b0;
    logic [31:0] IDEX_pc_in, IDEX_ir_in, IDEX_a_in, IDEX_b_in;
    logic        IDEX_ctrl_reg_dst_in, IDEX_ctrl_alu_src_in, IDEX_ctrl_branch_in;
    logic        IDEX_ctrl_reg_write_in, IDEX_ctrl_mem_to_reg_in;
    logic [1:0]  IDEX_ctrl_mem_read_in, IDEX_ctrl_mem_write_in;
    logic [31:0] EXMEM_alu_result_out, EXMEM_b_out, EXMEM_branch_target_out;
    logic [4:0]  EXMEM_reg_write_address_out;
    logic [1:0]  EXMEM_ctrl_mem_read_out, EXMEM_ctrl_mem_write_out;
    logic        EXMEM_ctrl_reg_write_out, EXMEM_ctrl_mem_to_reg_out;
    logic        EXMEM_branch_taken_out, stall_out;

    int   ecnt    = 0;
    int   n_total = 0;
    int   n_pass  = 0;
    exp_t q[$];
    exp_t         mon_e;
    logic [107:0] mon_act;

    ex_stage dut (
        .clk_in                      (clk_in),
        .n_rst_in                    (n_rst_in),
        .IDEX_pc_in                  (IDEX_pc_in),
        .IDEX_ir_in                  (IDEX_ir_in),
        .IDEX_a_in                   (IDEX_a_in),
        .IDEX_b_in                   (IDEX_b_in),
        .IDEX_ctrl_reg_dst_in        (IDEX_ctrl_reg_dst_in),
        .IDEX_ctrl_alu_src_in        (IDEX_ctrl_alu_src_in),
        .IDEX_ctrl_branch_in         (IDEX_ctrl_branch_in),
        .IDEX_ctrl_reg_write_in      (IDEX_ctrl_reg_write_in),
        .IDEX_ctrl_mem_to_reg_in     (IDEX_ctrl_mem_to_reg_in),
        .IDEX_ctrl_mem_read_in       (IDEX_ctrl_mem_read_in),
        .IDEX_ctrl_mem_write_in      (IDEX_ctrl_mem_write_in),
        .EXMEM_alu_result_out        (EXMEM_alu_result_out),
        .EXMEM_b_out                 (EXMEM_b_out),
        .EXMEM_reg_write_address_out (EXMEM_reg_write_address_out),
        .EXMEM_ctrl_mem_read_out     (EXMEM_ctrl_mem_read_out),
        .EXMEM_ctrl_mem_write_out    (EXMEM_ctrl_mem_write_out),
        .EXMEM_ctrl_reg_write_out    (EXMEM_ctrl_reg_write_out),
        .EXMEM_ctrl_mem_to_reg_out   (EXMEM_ctrl_mem_to_reg_out),
        .EXMEM_branch_taken_out      (EXMEM_branch_taken_out),
        .EXMEM_branch_target_out     (EXMEM_branch_target_out),
        .stall_out                   (stall_out)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) ecnt <= ecnt + 1;

    function automatic logic [107:0] pk(input logic [31:0] res, input logic [31:0] b,
                                        input logic [31:0] tgt, input logic [4:0] rd,
                                        input logic [1:0] mr, input logic [1:0] mw,
                                        input logic rw, input logic m2r, input logic tk);
        return {res, b, tgt, rd, mr, mw, rw, m2r, tk};
    endfunction

    function automatic logic [31:0] r_i(input logic [4:0] rd, input logic [4:0] sh,
                                        input logic [5:0] fn);
        return {OP_R, 5'd1, 5'd2, rd, sh, fn};
    endfunction

    function automatic logic [31:0] i_i(input logic [5:0] op, input logic [4:0] rt,
                                        input logic [15:0] imm);
        return {op, 5'd1, rt, imm};
    endfunction

    function automatic in_t mk(input logic [31:0] pc, input logic [31:0] ir,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic rdst, input logic asrc, input logic br,
                               input logic rw, input logic m2r,
                               input logic [1:0] mr, input logic [1:0] mw);
        in_t x;
        x.pc = pc; x.ir = ir; x.a = a; x.b = b;
        x.rdst = rdst; x.asrc = asrc; x.br = br; x.rw = rw; x.m2r = m2r;
        x.mr = mr; x.mw = mw;
        return x;
    endfunction

    task automatic apply(input in_t x);
        IDEX_pc_in              = x.pc;
        IDEX_ir_in              = x.ir;
        IDEX_a_in               = x.a;
        IDEX_b_in               = x.b;
        IDEX_ctrl_reg_dst_in    = x.rdst;
        IDEX_ctrl_alu_src_in    = x.asrc;
        IDEX_ctrl_branch_in     = x.br;
        IDEX_ctrl_reg_write_in  = x.rw;
        IDEX_ctrl_mem_to_reg_in = x.m2r;
        IDEX_ctrl_mem_read_in   = x.mr;
        IDEX_ctrl_mem_write_in  = x.mw;
    endtask

    // Keep the queue ordered by edge so the monitor can pop from the front
    task automatic push(input int cyc, input bit ck_ex, input bit ck_st,
                        input logic [107:0] ex, input logic st, input logic [63:0] name);
        exp_t e;
        int   i;
        e.cyc = cyc; e.ck_ex = ck_ex; e.ck_st = ck_st; e.ex = ex; e.st = st; e.name = name;
        i = 0;
        while (i < q.size() && q[i].cyc <= cyc) i++;
        q.insert(i, e);
    endtask

    // Present a single-cycle instruction; called at posedge+1
    task automatic issue(input in_t x, input logic [107:0] ex, input logic [63:0] name);
        int e0;
        e0 = ecnt;
        apply(x);
        push(e0, 1'b0, 1'b1, '0, 1'b0, name);
        push(e0 + 1, 1'b1, 1'b0, ex, 1'b0, name);
        @(posedge clk_in);
        #1;
    endtask

    // Present a MUL and hold it through the stall and DONE cycles
    task automatic issue_mul(input in_t x, input logic [31:0] prod, input logic [63:0] name);
        int e0;
        e0 = ecnt;
        apply(x);
        for (int k = 0; k <= 32; k++) push(e0 + k, 1'b0, 1'b1, '0, 1'b1, name);
        push(e0 + 33, 1'b0, 1'b1, '0, 1'b0, name);
        push(e0 + 1, 1'b1, 1'b0, '0, 1'b0, name);
        push(e0 + 33, 1'b1, 1'b0, '0, 1'b0, name);
        push(e0 + 34, 1'b1, 1'b0, pk(prod, x.b, 32'h0, x.ir[15:11], 2'd0, 2'd0, 1'b1, 1'b0, 1'b0), 1'b0, name);
        repeat (34) @(posedge clk_in);
        #1;
    endtask

    // Scoreboard monitor
    always @(negedge clk_in) begin
        while (q.size() > 0 && q[0].cyc <= ecnt) begin
            mon_e   = q.pop_front();
            mon_act = pk(EXMEM_alu_result_out, EXMEM_b_out, EXMEM_branch_target_out,
                         EXMEM_reg_write_address_out, EXMEM_ctrl_mem_read_out,
                         EXMEM_ctrl_mem_write_out, EXMEM_ctrl_reg_write_out,
                         EXMEM_ctrl_mem_to_reg_out, EXMEM_branch_taken_out);
            if (mon_e.ck_ex) begin
                n_total++;
                if (mon_act === mon_e.ex) n_pass++;
                else $display("FAIL exmem %0s edge %0d: got %h want %h (res,b,tgt,rd,mr,mw,rw,m2r,tk)",
                              mon_e.name, mon_e.cyc, mon_act, mon_e.ex);
            end
            if (mon_e.ck_st) begin
                n_total++;
                if (stall_out === mon_e.st) n_pass++;
                else $display("FAIL stall %0s edge %0d: got %b want %b",
                              mon_e.name, mon_e.cyc, stall_out, mon_e.st);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        in_t nop;
        int  e0;
        nop = mk(32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);

        // Reset held with a MUL on ID/EX: no stall, all outputs zero
        apply(mk(32'h0, r_i(5'd12, 5'd0, 6'h18), 32'h5, 32'h6, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0));
        @(posedge clk_in); #1;
        push(ecnt, 1'b1, 1'b1, '0, 1'b0, "rst_hold");
        @(posedge clk_in); #1;
        apply(nop);
        n_rst_in = 1'b1;

        // ALU
        issue(mk(32'h4, r_i(5'd3, 5'd0, 6'h20), 32'h7FFFFFFF, 32'h1, 1, 0, 0, 1, 0, 2'd0, 2'd0),
              pk(32'h80000000, 32'h1, 32'h0, 5'd3, 2'd0, 2'd0, 1, 0, 0), "add");
        issue(mk(32'h8, r_i(5'd4, 5'd0, 6'h2A), 32'hFFFFFFFF, 32'h1, 1, 0, 0, 1, 0, 2'd0, 2'd0),
              pk(32'h1, 32'h1, 32'h0, 5'd4, 2'd0, 2'd0, 1, 0, 0), "slt");
        issue(mk(32'hC, r_i(5'd5, 5'd4, 6'h03), 32'h1234, 32'h80000000, 1, 0, 0, 1, 0, 2'd0, 2'd0),
              pk(32'hF8000000, 32'h80000000, 32'h0, 5'd5, 2'd0, 2'd0, 1, 0, 0), "sra");
        issue(mk(32'h10, i_i(OP_ADDI, 5'd6, 16'hFFFF), 32'h5, 32'hDEAD, 0, 1, 0, 1, 0, 2'd0, 2'd0),
              pk(32'h4, 32'hDEAD, 32'h0, 5'd6, 2'd0, 2'd0, 1, 0, 0), "addi");
        issue(mk(32'h14, i_i(OP_ORI, 5'd7, 16'hFFFF), 32'h0, 32'h0, 0, 1, 0, 1, 0, 2'd0, 2'd0),
              pk(32'h0000FFFF, 32'h0, 32'h0, 5'd7, 2'd0, 2'd0, 1, 0, 0), "ori");
        issue(mk(32'h18, i_i(OP_LUI, 5'd8, 16'h1234), 32'hFFFF, 32'h0, 0, 1, 0, 1, 0, 2'd0, 2'd0),
              pk(32'h12340000, 32'h0, 32'h0, 5'd8, 2'd0, 2'd0, 1, 0, 0), "lui");
        issue(mk(32'h1C, i_i(OP_XORI, 5'd11, 16'h8001), 32'hFFFF0000, 32'h0, 0, 1, 0, 1, 0, 2'd0, 2'd0),
              pk(32'hFFFF8001, 32'h0, 32'h0, 5'd11, 2'd0, 2'd0, 1, 0, 0), "xori");
        issue(mk(32'h20, i_i(OP_LW, 5'd9, 16'hFFFC), 32'h1000, 32'h0, 0, 1, 0, 1, 1, 2'd3, 2'd0),
              pk(32'h00000FFC, 32'h0, 32'h0, 5'd9, 2'd3, 2'd0, 1, 1, 0), "lw");
        issue(mk(32'h24, i_i(OP_SW, 5'd10, 16'h0008), 32'h2000, 32'hCAFEBABE, 0, 1, 0, 0, 0, 2'd0, 2'd3),
              pk(32'h00002008, 32'hCAFEBABE, 32'h0, 5'd10, 2'd0, 2'd3, 0, 0, 0), "sw");

        // Taken BEQ, then the younger instruction is a bubble
        issue(mk(32'h100, i_i(OP_BEQ, 5'd0, 16'hFFFE), 32'h5, 32'h5, 0, 0, 1, 0, 0, 2'd0, 2'd0),
              pk(32'h0, 32'h5, 32'hF8, 5'd0, 2'd0, 2'd0, 0, 0, 1), "beq");
        issue(mk(32'h104, r_i(5'd3, 5'd0, 6'h20), 32'h1, 32'h1, 1, 0, 0, 1, 0, 2'd0, 2'd0),
              '0, "sq_add");
        issue(mk(32'h104, i_i(OP_BNE, 5'd0, 16'h0004), 32'h7, 32'h7, 0, 0, 1, 0, 0, 2'd0, 2'd0),
              pk(32'h0, 32'h7, 32'h0, 5'd0, 2'd0, 2'd0, 0, 0, 0), "bne");

        // Back-to-back branches: second is squashed
        issue(mk(32'h200, i_i(OP_BLT, 5'd0, 16'h0004), 32'hFFFFFFFF, 32'h1, 0, 0, 1, 0, 0, 2'd0, 2'd0),
              pk(32'h0, 32'h1, 32'h210, 5'd0, 2'd0, 2'd0, 0, 0, 1), "blt");
        issue(mk(32'h204, i_i(OP_BEQ, 5'd0, 16'h0008), 32'h2, 32'h2, 0, 0, 1, 0, 0, 2'd0, 2'd0),
              '0, "sq_beq");
        issue(mk(32'h208, r_i(5'd3, 5'd0, 6'h20), 32'h2, 32'h3, 1, 0, 0, 1, 0, 2'd0, 2'd0),
              pk(32'h5, 32'h3, 32'h0, 5'd3, 2'd0, 2'd0, 1, 0, 0), "add2");

        // Jumps
        issue(mk(32'h40000010, {OP_JAL, 26'h10}, 32'h0, 32'h0, 0, 0, 0, 1, 0, 2'd0, 2'd0),
              pk(32'h40000010, 32'h0, 32'h40000040, 5'd31, 2'd0, 2'd0, 1, 0, 1), "jal");
        issue(mk(32'h40000044, i_i(OP_ORI, 5'd7, 16'h0001), 32'h0, 32'h0, 0, 1, 0, 1, 0, 2'd0, 2'd0),
              '0, "sq_ori");
        issue(mk(32'h48, {OP_R, 5'd1, 5'd0, 5'd0, 5'd0, 6'h08}, 32'h200, 32'h0, 1, 0, 0, 0, 0, 2'd0, 2'd0),
              pk(32'h0, 32'h0, 32'h200, 5'd0, 2'd0, 2'd0, 0, 0, 1), "jr");
        issue(mk(32'h4C, r_i(5'd3, 5'd0, 6'h20), 32'h1, 32'h1, 1, 0, 0, 1, 0, 2'd0, 2'd0),
              '0, "sq_add3");

        // MUL arriving while a redirect is visible is squashed without stalling
        issue(mk(32'h300, i_i(OP_BLE, 5'd0, 16'h0001), 32'h3, 32'h3, 0, 0, 1, 0, 0, 2'd0, 2'd0),
              pk(32'h0, 32'h3, 32'h304, 5'd0, 2'd0, 2'd0, 0, 0, 1), "ble");
        issue(mk(32'h304, r_i(5'd12, 5'd0, 6'h18), 32'hFFFFFFFF, 32'h3, 1, 0, 0, 1, 0, 2'd0, 2'd0),
              '0, "sq_mul");

        // Full multiply, then a following ADD
        issue_mul(mk(32'h304, r_i(5'd12, 5'd0, 6'h18), 32'hFFFFFFFF, 32'h3, 1, 0, 0, 1, 0, 2'd0, 2'd0),
                  32'hFFFFFFFD, "mul");
        issue(mk(32'h308, r_i(5'd3, 5'd0, 6'h20), 32'h1, 32'h2, 1, 0, 0, 1, 0, 2'd0, 2'd0),
              pk(32'h3, 32'h2, 32'h0, 5'd3, 2'd0, 2'd0, 1, 0, 0), "add_pm");

        // Asynchronous reset at BUSY cnt=10
        e0 = ecnt;
        apply(mk(32'h400, r_i(5'd13, 5'd0, 6'h18), 32'h5, 32'h7, 1, 0, 0, 1, 0, 2'd0, 2'd0));
        for (int k = 0; k <= 10; k++) push(e0 + k, 1'b0, 1'b1, '0, 1'b1, "mul_rst");
        push(e0 + 1, 1'b1, 1'b0, '0, 1'b0, "mul_rst");
        repeat (11) @(posedge clk_in);
        #3;
        n_rst_in = 1'b0;
        push(ecnt, 1'b1, 1'b1, '0, 1'b0, "rst_busy");
        @(posedge clk_in); #1;
        apply(nop);
        n_rst_in = 1'b1;

        issue(mk(32'h500, r_i(5'd3, 5'd0, 6'h22), 32'h10, 32'h3, 1, 0, 0, 1, 0, 2'd0, 2'd0),
              pk(32'hD, 32'h3, 32'h0, 5'd3, 2'd0, 2'd0, 1, 0, 0), "sub_rst");
        issue_mul(mk(32'h504, r_i(5'd14, 5'd0, 6'h18), 32'h12345678, 32'h10, 1, 0, 0, 1, 0, 2'd0, 2'd0),
                  32'h23456780, "mul2");
        issue(mk(32'h508, r_i(5'd3, 5'd0, 6'h24), 32'hF0F0, 32'hFF00, 1, 0, 0, 1, 0, 2'd0, 2'd0),
              pk(32'hF000, 32'hFF00, 32'h0, 5'd3, 2'd0, 2'd0, 1, 0, 0), "and");

        apply(nop);
        repeat (3) @(posedge clk_in);
        #1;
        n_total++;
        if (q.size() == 0) n_pass++;
        else $display("FAIL drain: %0d expectations never compared, want 0", q.size());
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
